// File: rtl/riscv_pkg.sv
// Shared RV32 pipeline definitions: canonical instruction encodings and the fetch FSM state type.
// Used by fetch, decode and the CPU top level.
package riscv_pkg;

  localparam logic [31:0] RV_NOP    = 32'h0000_0013;
  localparam logic [31:0] RV_EBREAK = 32'h0010_0073;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  function automatic logic is_ebreak(input logic [31:0] word);
    return word == RV_EBREAK;
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// Program counter register and next-PC mux: redirect load, +4 advance, otherwise hold.
// PC is word aligned at all times; PC+4 wraps modulo 2^WIDTH.
module fetch_pc_gen #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             load,
  input  logic [WIDTH-1:0] load_pc,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);

  logic [WIDTH-1:0] pc_next;

  assign pc_plus4 = pc + WIDTH'(4);

  // Redirect outranks sequential advance; with neither, the PC holds (stall, boot, halt).
  always_comb begin
    pc_next = pc;
    if (load) begin
      pc_next = load_pc & ALIGN_MASK;
    end else if (advance) begin
      pc_next = pc_plus4;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_PC & ALIGN_MASK;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch: owns the PC, drives imem, and registers each word into IF/ID (1-cycle latency).
// Stall holds PC and IF/ID; redirect flushes IF/ID with a bubble; EBREAK halts fetch until redirect.
module riscv_fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  output logic [WIDTH-1:0] imem_addr_o,
  input  logic [31:0]      imem_rdata_i,
  output logic             id_valid_o,
  output logic [31:0]      id_instr_o,
  output logic [WIDTH-1:0] id_pc_o,
  output logic [WIDTH-1:0] id_pc_plus4_o,
  output logic             halted_o
);

  import riscv_pkg::*;

  fetch_state_t     state;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] pc_plus4;
  logic             fetch_ok;
  logic             fetch_ebreak;
  logic             pc_load;
  logic             pc_advance;

  // A fetch is latched only in RUN with no redirect and no stall.
  assign fetch_ok     = (state == RUN) && !redirect_i && !stall_i;
  assign fetch_ebreak = fetch_ok && is_ebreak(imem_rdata_i);
  assign pc_load      = redirect_i && (state != BOOT);
  assign pc_advance   = fetch_ok && !fetch_ebreak;

  fetch_pc_gen #(
    .WIDTH    (WIDTH),
    .RESET_PC (RESET_PC)
  ) u_pc_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .advance  (pc_advance),
    .load     (pc_load),
    .load_pc  (redirect_pc_i),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  assign imem_addr_o = pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BOOT;
      id_valid_o    <= 1'b0;
      id_instr_o    <= RV_NOP;
      id_pc_o       <= '0;
      id_pc_plus4_o <= '0;
      halted_o      <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          state <= RUN;
        end
        RUN: begin
          if (redirect_i) begin
            id_valid_o <= 1'b0;
            id_instr_o <= RV_NOP;
          end else if (!stall_i) begin
            id_valid_o    <= 1'b1;
            id_instr_o    <= imem_rdata_i;
            id_pc_o       <= pc;
            id_pc_plus4_o <= pc_plus4;
            // The EBREAK itself still goes to decode as a valid instruction.
            if (fetch_ebreak) begin
              state    <= HALT;
              halted_o <= 1'b1;
            end
          end
        end
        HALT: begin
          if (redirect_i) begin
            state      <= RUN;
            halted_o   <= 1'b0;
            id_valid_o <= 1'b0;
            id_instr_o <= RV_NOP;
          end else if (!stall_i) begin
            id_valid_o <= 1'b0;
            id_instr_o <= RV_NOP;
          end
        end
        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed bench for riscv_fetch_stage: a behavioural model pushes expected IF/ID state per edge
// into a scoreboard queue that is popped and compared after each edge; a second instance covers PC wrap.
module tb_riscv_fetch_stage;

  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc4;
  logic        halted;

  logic        w_zero = 1'b0;
  logic [31:0] w_tgt  = 32'h0;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_pc;
  logic [31:0] w_pc4;
  logic        w_halted;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0020: return 32'h0010_0073;
      default:       return {a[11:0], 20'h00093};
    endcase
  endfunction

  assign imem_rdata = mem(imem_addr);
  assign w_rdata    = mem(w_addr);

  riscv_fetch_stage #(.WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_addr_o   (imem_addr),
    .imem_rdata_i  (imem_rdata),
    .id_valid_o    (id_valid),
    .id_instr_o    (id_instr),
    .id_pc_o       (id_pc),
    .id_pc_plus4_o (id_pc4),
    .halted_o      (halted)
  );

  riscv_fetch_stage #(.WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall_i       (w_zero),
    .redirect_i    (w_zero),
    .redirect_pc_i (w_tgt),
    .imem_addr_o   (w_addr),
    .imem_rdata_i  (w_rdata),
    .id_valid_o    (w_valid),
    .id_instr_o    (w_instr),
    .id_pc_o       (w_pc),
    .id_pc_plus4_o (w_pc4),
    .halted_o      (w_halted)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
    logic        halt;
  } exp_t;

  exp_t q[$];

  int npass  = 0;
  int ntotal = 0;

  // Model state: 0 = boot, 1 = run, 2 = halt
  int          ms;
  logic [31:0] mpc;
  logic [31:0] minstr;
  logic [31:0] mipc;
  logic [31:0] mipc4;
  logic        mvalid;
  logic        mhalt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    ms     = 0;
    mpc    = 32'h0;
    minstr = 32'h0000_0013;
    mipc   = 32'h0;
    mipc4  = 32'h0;
    mvalid = 1'b0;
    mhalt  = 1'b0;
    q.delete();
  endtask

  task automatic check_reset(input string name);
    check({name, ".addr"},   imem_addr, 32'h0);
    check({name, ".valid"},  {31'h0, id_valid}, 32'h0);
    check({name, ".instr"},  id_instr, 32'h0000_0013);
    check({name, ".pc"},     id_pc, 32'h0);
    check({name, ".pc4"},    id_pc4, 32'h0);
    check({name, ".halted"}, {31'h0, halted}, 32'h0);
  endtask

  task automatic tick(input string name, input logic st, input logic rd, input logic [31:0] tgt);
    logic [31:0] w;
    exp_t e;
    stall       = st;
    redirect    = rd;
    redirect_pc = tgt;
    case (ms)
      0: ms = 1;
      1: begin
        if (rd) begin
          mpc    = {tgt[31:2], 2'b00};
          mvalid = 1'b0;
          minstr = 32'h0000_0013;
        end else if (!st) begin
          w      = mem(mpc);
          mvalid = 1'b1;
          minstr = w;
          mipc   = mpc;
          mipc4  = mpc + 32'd4;
          if (w == 32'h0010_0073) begin
            ms    = 2;
            mhalt = 1'b1;
          end else begin
            mpc = mpc + 32'd4;
          end
        end
      end
      default: begin
        if (rd) begin
          ms     = 1;
          mhalt  = 1'b0;
          mpc    = {tgt[31:2], 2'b00};
          mvalid = 1'b0;
          minstr = 32'h0000_0013;
        end else if (!st) begin
          mvalid = 1'b0;
          minstr = 32'h0000_0013;
        end
      end
    endcase
    q.push_back('{addr: mpc, instr: minstr, pc: mipc, pc4: mipc4, valid: mvalid, halt: mhalt});
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({name, ".addr"},   imem_addr, e.addr);
    check({name, ".valid"},  {31'h0, id_valid}, {31'h0, e.valid});
    check({name, ".instr"},  id_instr, e.instr);
    check({name, ".pc"},     id_pc, e.pc);
    check({name, ".pc4"},    id_pc4, e.pc4);
    check({name, ".halted"}, {31'h0, halted}, {31'h0, e.halt});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    model_reset();
    #12;
    check_reset("reset");
    check("wrap.reset_addr", w_addr, 32'hFFFF_FFFC);
    rst_n = 1'b1;

    // Boot sequence and first fetches
    tick("e1", 1'b0, 1'b0, 32'h0);
    check("e1.valid_const", {31'h0, id_valid}, 32'h0);
    check("wrap.e1_addr", w_addr, 32'hFFFF_FFFC);
    tick("e2", 1'b0, 1'b0, 32'h0);
    check("e2.instr_const", id_instr, 32'h0050_0093);
    check("e2.pc_const", id_pc, 32'h0);
    check("e2.pc4_const", id_pc4, 32'h4);
    check("wrap.e2_addr", w_addr, 32'h0);
    check("wrap.e2_pc", w_pc, 32'hFFFF_FFFC);
    check("wrap.e2_pc4", w_pc4, 32'h0);
    check("wrap.e2_valid", {31'h0, w_valid}, 32'h1);
    tick("e3", 1'b0, 1'b0, 32'h0);
    check("e3.instr_const", id_instr, 32'h00A0_0113);
    check("e3.pc_const", id_pc, 32'h4);

    tick("run0", 1'b0, 1'b0, 32'h0);
    tick("run1", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick("stall", 1'b1, 1'b0, 32'h0);
    tick("resume0", 1'b0, 1'b0, 32'h0);
    check("resume0.pc_const", id_pc, 32'h10);
    tick("resume1", 1'b0, 1'b0, 32'h0);

    // Redirect overrides stall, target low bits dropped
    tick("redir_stall", 1'b1, 1'b1, 32'h0000_0103);
    check("redir_stall.addr_const", imem_addr, 32'h100);
    check("redir_stall.valid_const", {31'h0, id_valid}, 32'h0);
    tick("redir_tgt", 1'b0, 1'b0, 32'h0);
    check("redir_tgt.pc_const", id_pc, 32'h100);
    check("redir_tgt.valid_const", {31'h0, id_valid}, 32'h1);

    // Run into EBREAK at 0x20
    tick("to18", 1'b0, 1'b1, 32'h18);
    tick("f18", 1'b0, 1'b0, 32'h0);
    tick("f1c", 1'b0, 1'b0, 32'h0);
    tick("ebreak", 1'b0, 1'b0, 32'h0);
    check("ebreak.instr_const", id_instr, 32'h0010_0073);
    check("ebreak.valid_const", {31'h0, id_valid}, 32'h1);
    check("ebreak.halted_const", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 12; i++) begin
      tick("halt", (i == 4), 1'b0, 32'h0);
      check("halt.addr_const", imem_addr, 32'h20);
      check("halt.valid_const", {31'h0, id_valid}, 32'h0);
    end

    // Redirect out of HALT
    tick("redir40", 1'b0, 1'b1, 32'h40);
    check("redir40.halted_const", {31'h0, halted}, 32'h0);
    tick("f40", 1'b0, 1'b0, 32'h0);
    check("f40.pc_const", id_pc, 32'h40);
    tick("f44", 1'b0, 1'b0, 32'h0);

    // Halt again with valid IF/ID, then asynchronous reset mid-cycle
    tick("back20", 1'b0, 1'b1, 32'h20);
    tick("ebreak2", 1'b0, 1'b0, 32'h0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset("async");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tick("re1", 1'b0, 1'b0, 32'h0);
    tick("re2", 1'b0, 1'b0, 32'h0);
    check("re2.instr_const", id_instr, 32'h0050_0093);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
